fib_seq_ctrl: RTL and testbench

- Sequencing controller for the 11-bit Fibonacci add/subtract datapath: reg1 (n-1), reg2 (n-2), two's-complement select, RCA, magnitude stage and 4:1 input mux.
- Runs on the fast system clock and advances the datapath only on a single-cycle step enable (`tick`) from the clock divider.
- Adds a start/busy/done handshake, a programmable term count, abort, and phase/term status outputs.

---
 rtl/fib_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_fib_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: start/abort sequencer for the 11-bit Fibonacci add/subtract datapath.
// Define FIB_STEP_EN to add a synchronized single-step button as an alternative tick source.
module fib_seq_ctrl #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             tick,
   input  logic             start,
   input  logic             abort,
`ifdef FIB_STEP_EN
   input  logic             step_mode,
   input  logic             step,
`endif
   input  logic [CNT_W-1:0] n_terms,
   output logic [1:0]       mux,
   output logic             sel,
   output logic             clr,
   output logic             ld1,
   output logic             ld2,
   output logic             busy,
   output logic             done,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] term_idx
);
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD1, ADD, TURN, SUB, DONE} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, nt;
   logic stp, last;
`ifdef FIB_STEP_EN
   logic [2:0] sync;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) sync <= '0;
      else sync <= {sync[1:0], step};
   assign stp = step_mode ? (sync[1] & ~sync[2]) : tick;
`else
   assign stp = tick;
`endif
   // n_terms of 0 wraps to all-ones here, giving a full 2^CNT_W-term phase
   assign last = cnt == nt - CNT_W'(1);
   assign term_idx = cnt;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         state <= IDLE;
         cnt   <= '0;
         nt    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == IDLE && start && !abort) nt <= n_terms;
      end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      mux      = 2'b00;
      sel      = 1'b0;
      clr      = 1'b0;
      ld1      = 1'b0;
      ld2      = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      phase    = 2'b00;
      case (state)
         IDLE: begin
            busy = 1'b0;
            state_nx = start ? CLEAR : IDLE;
         end
         CLEAR: begin
            clr = 1'b1;
            state_nx = LOAD1;
         end
         LOAD1: begin
            mux = 2'b01;
            ld1 = stp;
            if (stp) begin
               state_nx = ADD;
               cnt_nx = '0;
            end
         end
         ADD: begin
            ld1 = stp;
            ld2 = stp;
            phase = 2'b01;
            if (stp) begin
               cnt_nx = cnt + CNT_W'(1);
               state_nx = last ? TURN : ADD;
            end
         end
         TURN: begin
            mux = 2'b10;
            sel = 1'b1;
            ld1 = stp;
            ld2 = stp;
            phase = 2'b10;
            if (stp) begin
               state_nx = SUB;
               cnt_nx = '0;
            end
         end
         SUB: begin
            sel = 1'b1;
            ld1 = stp;
            ld2 = stp;
            phase = 2'b11;
            if (stp) begin
               cnt_nx = cnt + CNT_W'(1);
               state_nx = last ? DONE : SUB;
            end
         end
         DONE: begin
            done = 1'b1;
            state_nx = IDLE;
            cnt_nx = '0;
         end
         default: state_nx = IDLE;
      endcase
      if (abort) begin
         state_nx = IDLE;
         cnt_nx = '0;
      end
   end
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: directed runs of fib_seq_ctrl; per-cycle expected outputs are queued and
// a negedge monitor pops and compares them.
module tb_fib_seq_ctrl;
   localparam int W = 4;
   localparam int I = 0, C = 1, L = 2, A = 3, T = 4, S = 5, D = 6;
   logic clk = 0, clr_n = 0, tick = 0, start = 0, abort = 0;
   logic [W-1:0] n_terms = '0;
   logic [1:0] mux, phase;
   logic sel, clr, ld1, ld2, busy, done;
   logic [W-1:0] term_idx;
   logic [13:0] q[$];
   string lq[$];
   string tn = "reset";
   logic [13:0] e, got;
   string nm;
   int n_vec = 0, n_bad = 0;

   fib_seq_ctrl #(.CNT_W(W)) dut (
      .clk(clk), .clr_n(clr_n), .tick(tick), .start(start), .abort(abort), .n_terms(n_terms),
      .mux(mux), .sel(sel), .clr(clr), .ld1(ld1), .ld2(ld2), .busy(busy), .done(done),
      .phase(phase), .term_idx(term_idx)
   );

   always #5 clk = ~clk;

   // expected Moore outputs for a hand-chosen state, tick level and term index
   function automatic logic [13:0] ex(int s, logic tk, int idx);
      logic [1:0] m, ph;
      logic sl, cl, l1, l2, b, dn;
      m = 2'b00; ph = 2'b00; sl = 0; cl = 0; l1 = 0; l2 = 0; dn = 0;
      b = (s != I);
      case (s)
         C: cl = 1;
         L: begin m = 2'b01; l1 = tk; end
         A: begin l1 = tk; l2 = tk; ph = 2'b01; end
         T: begin m = 2'b10; sl = 1; l1 = tk; l2 = tk; ph = 2'b10; end
         S: begin sl = 1; l1 = tk; l2 = tk; ph = 2'b11; end
         D: dn = 1;
         default: ;
      endcase
      return {m, sl, cl, l1, l2, b, dn, ph, idx[3:0]};
   endfunction

   task automatic cyc(int s, int idx, logic tk = 1, logic st = 0, logic ab = 0);
      @(posedge clk);
      #1;
      tick = tk;
      start = st;
      abort = ab;
      q.push_back(ex(s, tk, idx));
      lq.push_back(tn);
   endtask

   task automatic hold4(int s, int idx);
      cyc(s, idx, 0);
      cyc(s, idx, 0);
      cyc(s, idx, 0);
      cyc(s, idx, 1);
   endtask

   always @(negedge clk)
      if (q.size() != 0) begin
         e = q.pop_front();
         nm = lq.pop_front();
         got = {mux, sel, clr, ld1, ld2, busy, done, phase, term_idx};
         n_vec++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (mux sel clr ld1 ld2 busy done phase idx)", nm, got, e);
         end
      end

   initial begin
      cyc(I, 0, 1);
      cyc(I, 0, 1);
      clr_n = 1;
      tn = "n3_run";
      n_terms = 3;
      cyc(I, 0, 1, 1);
      cyc(C, 0);
      cyc(L, 0);
      cyc(A, 0); cyc(A, 1); cyc(A, 2);
      cyc(T, 3);
      cyc(S, 0); cyc(S, 1); cyc(S, 2);
      cyc(D, 3);
      cyc(I, 0); cyc(I, 0);
      tn = "n16_slow_tick";
      n_terms = 0;
      cyc(I, 0, 0, 1);
      cyc(C, 0, 0);
      hold4(L, 0);
      for (int i = 0; i < 16; i++) hold4(A, i);
      hold4(T, 0);
      for (int i = 0; i < 16; i++) hold4(S, i);
      cyc(D, 0, 0);
      cyc(I, 0, 0);
      tn = "abort_sub";
      n_terms = 6;
      cyc(I, 0, 1, 1);
      cyc(C, 0);
      cyc(L, 0);
      for (int i = 0; i < 6; i++) cyc(A, i);
      cyc(T, 6);
      for (int i = 0; i < 5; i++) cyc(S, i);
      cyc(S, 5, 1, 0, 1);
      cyc(I, 0); cyc(I, 0); cyc(I, 0);
      tn = "restart_after_abort";
      n_terms = 2;
      cyc(I, 0, 1, 1);
      cyc(C, 0);
      cyc(L, 0);
      cyc(A, 0); cyc(A, 1);
      cyc(T, 2);
      cyc(S, 0); cyc(S, 1);
      cyc(D, 2);
      cyc(I, 0);
      tn = "abort_clear_and_idle";
      cyc(I, 0, 1, 1);
      cyc(C, 0, 1, 0, 1);
      cyc(I, 0, 1, 1, 1);
      cyc(I, 0);
      cyc(I, 0);
      tn = "start_ignored_nterms_change";
      n_terms = 3;
      cyc(I, 0, 1, 1);
      cyc(C, 0);
      cyc(L, 0);
      cyc(A, 0);
      cyc(A, 1, 1, 1);
      n_terms = 7;
      cyc(A, 2);
      cyc(T, 3);
      cyc(S, 0); cyc(S, 1); cyc(S, 2);
      cyc(D, 3);
      cyc(I, 0); cyc(I, 0); cyc(I, 0);
      tn = "async_reset_mid_add";
      n_terms = 5;
      cyc(I, 0, 1, 1);
      cyc(C, 0);
      cyc(L, 0);
      cyc(A, 0);
      cyc(A, 1);
      @(posedge clk);
      #1;
      q.push_back(ex(I, 1, 0));
      lq.push_back(tn);
      #2;
      clr_n = 0;
      cyc(I, 0);
      cyc(I, 0);
      clr_n = 1;
      cyc(I, 0);
      cyc(I, 0);
      repeat (2) @(posedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d queued want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
